// File: rtl/fetch_unit.sv
// MIPS fetch stage: owns the PC, fetches over a req/ack handshake into an instruction register.
// Optional FETCH_PERF_CNT_EN adds a free-running count of accepted fetches (fetch_count).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        advance,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic [31:0] ext_imm,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [15:0] immediate16,
  output logic [25:0] immediate26,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] fetch_count,
`endif
  output logic        ext_select
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;

  assign pc_plus4 = pc + PC_STEP;

  // Jump keeps the region bits of pc+4; branch offset is a word count.
  always_comb begin
    next_pc = pc_plus4;
    if (jump)
      next_pc = {pc_plus4[31:28], ext_imm[25:0], 2'b00};
    else if (branch_taken)
      next_pc = pc_plus4 + (ext_imm << 2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_RESET;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
      fetch_count <= 32'h0;
`endif
    end else begin
      case (state)
        S_RESET: begin
          state    <= S_REQ;
          imem_req <= 1'b1;
        end
        S_REQ: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= S_HOLD;
`ifdef FETCH_PERF_CNT_EN
            fetch_count <= fetch_count + 32'd1;
`endif
          end
        end
        S_HOLD: begin
          if (advance && !stall) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= S_REQ;
          end
        end
        default: begin
          state    <= S_RESET;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr   = pc;
  assign immediate16 = instr[15:0];
  assign immediate26 = instr[25:0];
  assign ext_select  = (instr[31:26] == 6'b000010) || (instr[31:26] == 6'b000011);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus random bench for fetch_unit against a behavioural model of the fetch protocol.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        advance;
  logic        stall;
  logic        branch_taken;
  logic        jump;
  logic [31:0] ext_imm;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic [15:0] immediate16;
  logic [25:0] immediate26;
  logic        ext_select;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .advance(advance), .stall(stall), .branch_taken(branch_taken), .jump(jump), .ext_imm(ext_imm),
    .pc(pc), .instr(instr), .instr_valid(instr_valid),
    .immediate16(immediate16), .immediate26(immediate26),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count(fetch_count),
`endif
    .ext_select(ext_select)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: where the fetch protocol stands, in plain terms.
  logic [31:0] m_pc, m_instr, m_fc;
  logic        m_valid, m_req, m_idle;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] target(input logic [31:0] cur, input logic j, input logic b,
                                         input logic [31:0] e);
    logic [31:0] seq;
    seq = cur + 32'd4;
    if (j) return (seq & 32'hF000_0000) | ((e & 32'h03FF_FFFF) << 2);
    if (b) return seq + e * 32'd4;
    return seq;
  endfunction

  task automatic model_tick();
    if (!rst_n) begin
      m_pc = 32'h0; m_instr = 32'h0; m_valid = 1'b0; m_req = 1'b0; m_idle = 1'b1; m_fc = 32'h0;
    end else if (m_idle) begin
      m_idle = 1'b0; m_req = 1'b1;
    end else if (m_req) begin
      if (imem_ack) begin
        m_instr = imem_rdata; m_valid = 1'b1; m_req = 1'b0; m_fc = m_fc + 32'd1;
      end
    end else if (advance && !stall) begin
      m_pc = target(m_pc, jump, branch_taken, ext_imm);
      m_valid = 1'b0; m_req = 1'b1;
    end
  endtask

  task automatic check_all();
    logic [5:0] op;
    op = m_instr[31:26];
    check("pc", pc, m_pc);
    check("imem_addr", imem_addr, m_pc);
    check("instr", instr, m_instr);
    check("instr_valid", {31'h0, instr_valid}, {31'h0, m_valid});
    check("imem_req", {31'h0, imem_req}, {31'h0, m_req});
    check("immediate16", {16'h0, immediate16}, m_instr & 32'h0000_FFFF);
    check("immediate26", {6'h0, immediate26}, m_instr & 32'h03FF_FFFF);
    check("ext_select", {31'h0, ext_select}, {31'h0, (op == 6'd2 || op == 6'd3)});
`ifdef FETCH_PERF_CNT_EN
    check("fetch_count", fetch_count, m_fc);
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    model_tick();
    @(negedge clk);
    check_all();
  endtask

  task automatic fetch(input logic [31:0] word);
    imem_ack = 1'b1; imem_rdata = word;
    cyc();
    imem_ack = 1'b0;
  endtask

  task automatic adv(input logic j, input logic b, input logic [31:0] e);
    advance = 1'b1; jump = j; branch_taken = b; ext_imm = e;
    cyc();
    advance = 1'b0; jump = 1'b0; branch_taken = 1'b0;
  endtask

  // From S_REQ: fetch a filler word, then branch to an aligned address.
  task automatic go_to(input logic [31:0] dest);
    fetch($urandom);
    adv(1'b0, 1'b1, (dest - m_pc - 32'd4) >> 2);
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; advance = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; jump = 1'b0; ext_imm = 32'h0;
    m_pc = 32'h0; m_instr = 32'h0; m_fc = 32'h0; m_valid = 1'b0; m_req = 1'b0; m_idle = 1'b1;

    cyc(); cyc();
    check("rst_pc", pc, 32'h0);
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);

    rst_n = 1'b1;
    cyc();
    check("first_req", {31'h0, imem_req}, 32'h1);
    check("first_addr", imem_addr, 32'h0);
    fetch(32'h2008_0005);
    check("first_instr", instr, 32'h2008_0005);
    check("first_imm16", {16'h0, immediate16}, 32'h5);
    check("first_extsel", {31'h0, ext_select}, 32'h0);

    adv(1'b1, 1'b0, 32'h4);
    check("jump_to_10", pc, 32'h10);
    fetch($urandom);
    adv(1'b0, 1'b0, $urandom);
    check("seq_pc", pc, 32'h14);
    check("seq_addr", imem_addr, 32'h14);
    check("seq_req", {31'h0, imem_req}, 32'h1);

    go_to(32'h10);
    fetch($urandom);
    adv(1'b0, 1'b1, 32'h3);
    check("branch_pc", pc, 32'h20);

    go_to(32'h1000_0000);
    fetch(32'h0800_0040);
    check("j_extsel", {31'h0, ext_select}, 32'h1);
    check("j_imm26", {6'h0, immediate26}, 32'h40);
    adv(1'b1, 1'b1, 32'h40);
    check("jump_prio", pc, 32'h1000_0100);

    fetch(32'hDEAD_BEEF);
    stall = 1'b1; advance = 1'b1;
    repeat (3) cyc();
    check("stall_pc", pc, 32'h1000_0100);
    check("stall_instr", instr, 32'hDEAD_BEEF);
    stall = 1'b0;
    adv(1'b0, 1'b0, 32'h0);
    check("post_stall_pc", pc, 32'h1000_0104);

    rst_n = 1'b0;
    cyc();
    check("rst_req_drop", {31'h0, imem_req}, 32'h0);
    rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    cyc();
    imem_ack = 1'b0;
    check("late_ack_valid", {31'h0, instr_valid}, 32'h0);
    check("late_ack_instr", instr, 32'h0);
    check("rst_pc2", pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("fc_after_rst", fetch_count, 32'h0);
`endif

    go_to(32'hFFFF_FFFC);
    check("pre_wrap", pc, 32'hFFFF_FFFC);
    fetch($urandom);
    adv(1'b0, 1'b0, 32'h0);
    check("wrap", pc, 32'h0);

    for (int i = 0; i < 800; i++) begin
      rst_n        = ($urandom_range(0, 63) != 0);
      imem_ack     = $urandom_range(0, 1);
      imem_rdata   = $urandom_range(0, 2) == 0 ? {5'b00001, 27'($urandom)} : $urandom;
      advance      = $urandom_range(0, 1);
      stall        = ($urandom_range(0, 3) == 0);
      jump         = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 2) == 0);
      ext_imm      = $urandom;
      cyc();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
